wb_uart_lite: RTL and testbench
===============================

WB_UART_LITE -- requirements
Module: wb_uart_lite

Interface
REQ-001 SHALL have parameter DIV_DEFAULT, default 16'd434, reset value of BAUDDIV (clocks per bit).
REQ-002 SHALL have parameter RX_FIFO_DEPTH, default 4, RX FIFO entries (power of 2; used only when UART_RX_FIFO_EN is defined).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports wb_adr_i input 8 (byte address), wb_dat_i input 32, wb_sel_i input 4, wb_we_i input 1, wb_cyc_i input 1, wb_stb_i input 1, all Wishbone classic slave inputs.
REQ-006 SHALL have ports wb_dat_o output 32 (read data) and wb_ack_o output 1 (cycle acknowledge).
REQ-007 SHALL have ports uart_tx_o output 1 (serial out, idle high), uart_rx_i input 1 (asynchronous serial in) and irq_o output 1 (level interrupt).

Function
REQ-008 SHALL assert wb_ack_o for exactly one cycle, one cycle after cyc&stb&~ack is sampled high; every address is acked, with no wait states and no error.
REQ-009 SHALL perform register side effects only on the cycle wb_ack_o is driven high; wb_dat_o is valid in that same cycle.
REQ-010 SHALL implement register map: 0x00 TXDATA (W, byte [7:0], needs wb_sel_i[0]), 0x04 RXDATA (R), 0x08 STATUS, 0x0C BAUDDIV [15:0] R/W, 0x10 CTRL [1:0] R/W.
REQ-011 SHALL return 0 on reads of TXDATA and of unmapped addresses; writes to those addresses are ignored.
REQ-012 SHALL define STATUS as: bit0 tx_busy, bit1 rx_valid, bit2 rx_overrun (sticky), bit3 rx_frame_err (sticky), bit4 tx_drop (sticky); writing 1 to bits 2..4 clears them.
REQ-013 SHALL return {rx_valid, 23'b0, rx_byte} on an RXDATA read and pop one entry when rx_valid=1; a read when empty returns 0 with no side effect.
REQ-014 SHALL clamp BAUDDIV writes below 4 to 4.
REQ-015 SHALL latch BAUDDIV at frame start in the TX and RX engines; changes take effect from the next frame.
REQ-016 SHALL run a TX FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE, each bit lasting exactly BAUDDIV clocks.
REQ-017 SHALL leave TX IDLE in the cycle after the TXDATA write ack; tx_busy=1 from that cycle until STOP completes.
REQ-018 SHALL drop a TXDATA write made while tx_busy=1 and set tx_drop.
REQ-019 SHALL pass uart_rx_i through a 2-flop synchronizer with both flops reset to 1.
REQ-020 SHALL run an RX FSM IDLE->START->DATA->STOP: a synchronized falling edge enters START, the line is sampled at BAUDDIV/2, then every BAUDDIV clocks.
REQ-021 SHALL return RX to IDLE without a byte if the line is high at the START sample (glitch rejection).
REQ-022 SHALL set rx_frame_err and discard the byte if the STOP sample is 0.
REQ-023 SHALL discard a new byte arriving while the RX buffer is full and set rx_overrun.
REQ-024 SHALL, when a pop and a push coincide in the same cycle, perform both with no overrun.
REQ-025 SHALL drive irq_o = (CTRL[0] & rx_valid) | (CTRL[1] & ~tx_busy), registered.

Reset
REQ-026 SHALL, on reset_n low, asynchronously set uart_tx_o=1, wb_ack_o=0, wb_dat_o=0, irq_o=0, both FSMs IDLE, RX buffer empty, all STATUS bits 0, CTRL=0, BAUDDIV=DIV_DEFAULT.
REQ-027 SHALL abort a frame in progress when reset is asserted mid-frame, with no partial byte retained.

Configuration
REQ-028 SHALL, with UART_RX_FIFO_EN defined, buffer received bytes in a RX_FIFO_DEPTH-entry FIFO; rx_valid = not empty.
REQ-029 SHALL, without UART_RX_FIFO_EN, use a single holding register; rx_valid = register full.

Verification
REQ-030 SHALL verify TX: BAUDDIV=8, write 0x55 -> uart_tx_o low 8 clocks, then 1,0,1,0,1,0,1,0 for 8 clocks each, then high; tx_busy clears after 80 clocks.
REQ-031 SHALL verify RX: BAUDDIV=8, drive 0xA3 frame -> RXDATA reads 0x800000A3, then the next read returns 0x00000000.
REQ-032 SHALL verify overrun: send 5 bytes 0x01..0x05 with no reads -> with FIFO, reads give 0x01..0x04 and overrun=1; without FIFO, read gives 0x01 and overrun=1.
REQ-033 SHALL verify errors: a stop bit of 0 -> frame_err=1 and rx_valid=0; a 2-clock low glitch -> no byte received.
REQ-034 SHALL verify drop and reset: a second TXDATA write during a frame -> tx_drop=1; reset_n low mid-frame -> uart_tx_o=1 immediately and STATUS reads 0.

Source files
------------

// File: rtl/wb_uart_lite.sv
// wb_uart_lite: Wishbone UART; define UART_RX_FIFO_EN for an RX FIFO instead of a single holding register
module wb_uart_lite #(
  parameter logic [15:0] DIV_DEFAULT = 16'd434,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i,
  output logic        irq_o
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic ack_q, ack_d, pop_q, pop_d, ovr_q, ovr_d, fe_q, fe_d, drop_q, drop_d, irq_q, irq_d;
  logic tx_line_q, tx_line_d, rx_s1_q, rx_s2_q, rx_prev_q;
  logic [31:0] dat_q, dat_d, rdata;
  logic [15:0] baud_q, baud_d, tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d, rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, head;
  logic [1:0] ctrl_q, ctrl_d;
  logic req, wr, tx_wr, st_wr, tx_busy, tx_end, rx_end, rx_mid;
  logic rx_valid, full, push, push_ok, pop, fe_set;
  logic unused_ok;
  assign unused_ok = ^{wb_sel_i[3:1], wb_dat_i[31:16]};
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign uart_tx_o = tx_line_q;
  assign irq_o = irq_q;
  // Bus decode: read data is captured with the ack, writes and pops take effect at the end of the ack cycle
  always_comb begin
    req = wb_cyc_i & wb_stb_i & ~ack_q;
    wr = wb_cyc_i & wb_stb_i & wb_we_i & ack_q;
    tx_wr = wr & (wb_adr_i == 8'h00) & wb_sel_i[0];
    st_wr = wr & (wb_adr_i == 8'h08);
    tx_busy = tx_st_q != IDLE;
    rdata = wb_adr_i == 8'h04 ? (rx_valid ? {1'b1, 23'b0, head} : 32'b0) :
            wb_adr_i == 8'h08 ? {27'b0, drop_q, fe_q, ovr_q, rx_valid, tx_busy} :
            wb_adr_i == 8'h0C ? {16'b0, baud_q} :
            wb_adr_i == 8'h10 ? {30'b0, ctrl_q} : 32'b0;
    ack_d = req;
    dat_d = (req & ~wb_we_i) ? rdata : 32'b0;
    pop_d = req & ~wb_we_i & (wb_adr_i == 8'h04) & rx_valid;
    pop = pop_q;
    baud_d = (wr & (wb_adr_i == 8'h0C)) ? (wb_dat_i[15:0] < 16'd4 ? 16'd4 : wb_dat_i[15:0]) : baud_q;
    ctrl_d = (wr & (wb_adr_i == 8'h10)) ? wb_dat_i[1:0] : ctrl_q;
    push_ok = push & (~full | pop);
    ovr_d = (push & full & ~pop) | (ovr_q & ~(st_wr & wb_dat_i[2]));
    fe_d = fe_set | (fe_q & ~(st_wr & wb_dat_i[3]));
    drop_d = (tx_wr & tx_busy) | (drop_q & ~(st_wr & wb_dat_i[4]));
    irq_d = (ctrl_q[0] & rx_valid) | (ctrl_q[1] & ~tx_busy);
  end
  // TX engine: start, 8 data bits LSB first, stop; line registered from the next state
  always_comb begin
    tx_st_d = tx_st_q;
    tx_cnt_d = tx_cnt_q + 16'd1;
    tx_div_d = tx_div_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_end = tx_cnt_q == tx_div_q - 16'd1;
    case (tx_st_q)
      IDLE: begin
        tx_cnt_d = '0;
        if (tx_wr) begin
          tx_st_d = START;
          tx_div_d = baud_q;
          tx_sh_d = wb_dat_i[7:0];
        end
      end
      START: if (tx_end) begin
        tx_st_d = DATA;
        tx_cnt_d = '0;
        tx_bit_d = '0;
      end
      DATA: if (tx_end) begin
        tx_cnt_d = '0;
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_st_d = STOP;
      end
      default: if (tx_end) begin
        tx_st_d = IDLE;
        tx_cnt_d = '0;
      end
    endcase
    tx_line_d = tx_st_d == START ? 1'b0 : tx_st_d == DATA ? tx_sh_d[0] : 1'b1;
  end
  // RX engine: falling edge starts a frame, sample mid start bit, then once per bit period
  always_comb begin
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_cnt_q + 16'd1;
    rx_div_d = rx_div_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    push = 1'b0;
    fe_set = 1'b0;
    rx_end = rx_cnt_q == rx_div_q - 16'd1;
    rx_mid = rx_cnt_q == (rx_div_q >> 1) - 16'd1;
    case (rx_st_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q & ~rx_s2_q) begin
          rx_st_d = START;
          rx_div_d = baud_q;
        end
      end
      START: if (rx_mid) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d = rx_s2_q ? IDLE : DATA;
      end
      DATA: if (rx_end) begin
        rx_cnt_d = '0;
        rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = STOP;
      end
      default: if (rx_end) begin
        rx_st_d = IDLE;
        rx_cnt_d = '0;
        push = rx_s2_q;
        fe_set = ~rx_s2_q;
      end
    endcase
  end
`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  logic [7:0] mem_q [RX_FIFO_DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  // FIFO pointers carry a wrap bit to tell full from empty
  always_comb begin
    wp_d = wp_q + (AW+1)'(push_ok);
    rp_d = rp_q + (AW+1)'(pop);
    full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    rx_valid = wp_q != rp_q;
    head = mem_q[rp_q[AW-1:0]];
  end
  // FIFO pointer registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  // FIFO storage; contents are qualified by the pointers so no reset
  always_ff @(posedge clk)
    if (push_ok) mem_q[wp_q[AW-1:0]] <= rx_sh_q;
`else
  localparam int unused_depth = RX_FIFO_DEPTH;
  logic full_q, full_d;
  logic [7:0] hold_q, hold_d;
  // Single holding register; a pop and push together keep it full with the new byte
  always_comb begin
    full_d = push_ok | (full_q & ~pop);
    hold_d = push_ok ? rx_sh_q : hold_q;
    full = full_q;
    rx_valid = full_q;
    head = hold_q;
  end
  // Holding register state
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      full_q <= 1'b0;
      hold_q <= '0;
    end else begin
      full_q <= full_d;
      hold_q <= hold_d;
    end
`endif
  // All control state, with the serial input synchronizer idling high
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      pop_q <= 1'b0;
      baud_q <= DIV_DEFAULT;
      ctrl_q <= '0;
      {ovr_q, fe_q, drop_q, irq_q} <= '0;
      tx_st_q <= IDLE;
      {tx_cnt_q, tx_div_q, tx_bit_q, tx_sh_q} <= '0;
      tx_line_q <= 1'b1;
      rx_st_q <= IDLE;
      {rx_cnt_q, rx_div_q, rx_bit_q, rx_sh_q} <= '0;
      {rx_s1_q, rx_s2_q, rx_prev_q} <= 3'b111;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      pop_q <= pop_d;
      baud_q <= baud_d;
      ctrl_q <= ctrl_d;
      {ovr_q, fe_q, drop_q, irq_q} <= {ovr_d, fe_d, drop_d, irq_d};
      tx_st_q <= tx_st_d;
      {tx_cnt_q, tx_div_q, tx_bit_q, tx_sh_q} <= {tx_cnt_d, tx_div_d, tx_bit_d, tx_sh_d};
      tx_line_q <= tx_line_d;
      rx_st_q <= rx_st_d;
      {rx_cnt_q, rx_div_q, rx_bit_q, rx_sh_q} <= {rx_cnt_d, rx_div_d, rx_bit_d, rx_sh_d};
      {rx_s1_q, rx_s2_q, rx_prev_q} <= {uart_rx_i, rx_s1_q, rx_s2_q};
    end
endmodule

// File: tb/tb_wb_uart_lite.sv
// tb_wb_uart_lite: directed and randomized checks of wb_uart_lite against a queue-based model
module tb_wb_uart_lite;
  logic clk = 0, reset_n = 0;
  logic [7:0] wb_adr_i = 0;
  logic [31:0] wb_dat_i = 0;
  logic [3:0] wb_sel_i = 0;
  logic wb_we_i = 0, wb_cyc_i = 0, wb_stb_i = 0, uart_rx_i = 1;
  logic [31:0] wb_dat_o;
  logic wb_ack_o, uart_tx_o, irq_o;
  int checks = 0, errors = 0, div = 8;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  logic [7:0] q[$];
  logic ovr = 0, fe = 0, drop = 0;
  logic [31:0] r;

  wb_uart_lite dut (.clk(clk), .reset_n(reset_n), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i), .irq_o(irq_o));

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic [7:0] a, input logic [31:0] d, input logic w, output logic [31:0] rd);
    int lat = 0;
    @(negedge clk);
    wb_adr_i = a; wb_dat_i = d; wb_we_i = w; wb_sel_i = 4'hF; wb_cyc_i = 1; wb_stb_i = 1;
    rd = '0;
    for (int i = 1; i <= 4 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        lat = i;
        rd = wb_dat_o;
      end
    end
    check("ack_latency", lat, 1);
    @(posedge clk); #1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    check("ack_single", {31'b0, wb_ack_o}, 0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb(a, d, 1'b1, dummy);
  endtask

  function automatic logic [31:0] st(input logic busy);
    return {27'b0, drop, fe, ovr, q.size() > 0, busy};
  endfunction

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    wb(a, 32'b0, 1'b0, v);
    check(tag, v, exp);
  endtask

  task automatic rx_pop(input string tag);
    logic [31:0] exp;
    exp = q.size() > 0 ? {1'b1, 23'b0, q.pop_front()} : 32'b0;
    rd_check(tag, 8'h04, exp);
  endtask

  task automatic send(input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx_i = f[i];
      repeat (div) @(posedge clk);
    end
    uart_rx_i = 1;
    repeat (3) @(posedge clk);
    if (!stopb) fe = 1;
    else if (q.size() < CAP) q.push_back(b);
    else ovr = 1;
  endtask

  task automatic tx_frame(input string tag, input logic [7:0] b, input logic ien);
    logic [255:0] ol, el, oi, ei;
    logic [9:0] f;
    int n;
    f = {1'b1, b, 1'b0};
    n = 10 * div;
    ol = '0; el = '0; oi = '0; ei = '0;
    wr(8'h00, {24'b0, b});
    for (int c = 0; c < n + 8; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      ol[c] = uart_tx_o;
      el[c] = c < n ? f[c / div] : 1'b1;
      oi[c] = irq_o;
      ei[c] = ien & (c == 0 || c > n);
    end
    checks++;
    assert (ol === el) else begin
      errors++;
      $error("FAIL %s_line observed=%h expected=%h", tag, ol, el);
    end
    checks++;
    assert (oi === ei) else begin
      errors++;
      $error("FAIL %s_irq observed=%h expected=%h", tag, oi, ei);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1;
    #1;
    check("rst_tx", {31'b0, uart_tx_o}, 1);
    check("rst_ack", {31'b0, wb_ack_o}, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_irq", {31'b0, irq_o}, 0);
    rd_check("rst_status", 8'h08, 0);
    rd_check("rst_baud", 8'h0C, 434);
    rd_check("rst_ctrl", 8'h10, 0);
    rd_check("rst_rxdata", 8'h04, 0);
    rd_check("txdata_read", 8'h00, 0);
    wr(8'h14, 32'hFFFF_FFFF);
    rd_check("unmapped_read", 8'h14, 0);
    wr(8'h0C, 2);
    rd_check("baud_clamp", 8'h0C, 4);
    wr(8'h0C, 32'hABCD_0008);
    rd_check("baud_write", 8'h0C, 8);
    wr(8'h10, 2);
    rd_check("ctrl_write", 8'h10, 2);
    tx_frame("tx55", 8'h55, 1'b1);
    rd_check("tx_idle_status", 8'h08, st(0));
    div = $urandom_range(4, 12);
    wr(8'h0C, div);
    tx_frame("tx_rand", 8'($urandom), 1'b1);
    div = 8;
    wr(8'h0C, div);
    wr(8'h10, 0);
    wr(8'h00, 32'hA5);
    rd_check("busy_status", 8'h08, st(1));
    wr(8'h00, 32'h3C);
    drop = 1;
    rd_check("drop_status", 8'h08, st(1));
    repeat (90) @(posedge clk);
    rd_check("drop_sticky", 8'h08, st(0));
    wr(8'h08, 32'h1C);
    drop = 0;
    rd_check("drop_clear", 8'h08, st(0));
    wr(8'h10, 1);
    send(8'hA3, 1'b1);
    #1;
    check("irq_rx", {31'b0, irq_o}, 1);
    rd_check("rx_status", 8'h08, st(0));
    rx_pop("rx_a3");
    rx_pop("rx_empty");
    check("irq_rx_clear", {31'b0, irq_o}, 0);
    wr(8'h10, 0);
    for (int b = 1; b <= 5; b++) send(8'(b), 1'b1);
    rd_check("ovr_status", 8'h08, st(0));
    for (int i = 0; i <= CAP; i++) rx_pop("ovr_drain");
    wr(8'h08, 32'h04);
    ovr = 0;
    send(8'h5A, 1'b0);
    rd_check("frame_err_status", 8'h08, st(0));
    rx_pop("frame_err_nobyte");
    wr(8'h08, 32'h08);
    fe = 0;
    uart_rx_i = 0;
    repeat (2) @(posedge clk);
    uart_rx_i = 1;
    repeat (40) @(posedge clk);
    rd_check("glitch_status", 8'h08, st(0));
    rx_pop("glitch_nobyte");
    for (int k = 0; k < 10; k++) begin
      div = $urandom_range(5, 12);
      wr(8'h0C, div);
      send(8'($urandom), 1'b1);
      if ($urandom_range(0, 2) != 0) rx_pop("rx_rand");
    end
    rd_check("rand_status", 8'h08, st(0));
    while (q.size() > 0) rx_pop("rx_rand_drain");
    rx_pop("rx_rand_empty");
    wr(8'h08, 32'h1C);
    ovr = 0;
    div = 8;
    wr(8'h0C, div);
    wr(8'h00, 32'h00);
    wr(8'h00, 32'hFF);
    drop = 1;
    rd_check("pre_reset_status", 8'h08, st(1));
    uart_rx_i = 0;
    repeat (12) @(posedge clk);
    #3 reset_n = 0;
    #1;
    check("reset_tx_now", {31'b0, uart_tx_o}, 1);
    check("reset_ack_now", {31'b0, wb_ack_o}, 0);
    q.delete();
    drop = 0; fe = 0; ovr = 0;
    repeat (2) @(posedge clk);
    uart_rx_i = 1;
    @(negedge clk) reset_n = 1;
    rd_check("post_reset_status", 8'h08, st(0));
    rd_check("post_reset_baud", 8'h0C, 434);
    wr(8'h0C, div);
    repeat (120) @(posedge clk);
    rx_pop("post_reset_nobyte");
    rd_check("post_reset_status2", 8'h08, st(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
